seg7_scan_capture: RTL and testbench
====================================

// Module: seg7_scan_capture
// PURPOSE
//  Receive side of the multiplexed 7-segment display interface: samples the segment
//  lines (a..g) and one-hot digit-select lines of a scanned display and recovers one
//  BCD digit per position. Flags blank digits and illegal patterns. Delivers complete
//  frames through a valid/ready handshake. Sits between display pins and a test/monitor host.
// PARAMETERS
//  NDIG        4   number of scanned digit positions (2..8)
//  STABLE_CYC  8   cycles SEG and DIG must stay unchanged before a digit is sampled (>=2)
//  CNT_W       4   settle-counter width; 2**CNT_W > STABLE_CYC
// PORTS
//  CLK        in   1       single clock, rising edge
//  RST        in   1       asynchronous, active-high reset
//  SEG        in   7       segment lines, active high; SEG[6]=a ... SEG[0]=g; asynchronous
//  DIG        in   NDIG    digit select, active high, one-hot when valid; asynchronous
//  FRAME_RDY  in   1       consumer accepts frame
//  FRAME_VLD  out  1       frame outputs valid
//  BCD        out  4*NDIG  digit k in BCD[4k+3:4k]
//  BLANK      out  NDIG    digit k was all segments off
//  ERR        out  NDIG    digit k pattern not in decode table
//  OVR        out  1       sticky: a frame was dropped while output stalled
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, capture mask clear, counter 0.
//  - SEG and DIG each pass a 2-flop synchronizer; all logic below uses synchronized values.
//  - Decode table (abcdefg): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011
//    5=1011011 6=0011111 or 1011111, 7=1110000, 8=1111111, 9=1110011 or 1111011.
//    0000000 -> BCD 0, BLANK=1. Any other pattern -> BCD 4'hF, ERR=1.
//  - FSM IDLE: DIG one-hot -> SETTLE (counter=0, latch DIG/SEG). Otherwise stay.
//  - SETTLE: each cycle SEG/DIG equal latched -> counter+1; any change -> counter=0 and
//    relatch; DIG not one-hot -> IDLE. Counter reaching STABLE_CYC-1 -> CAPTURE.
//  - CAPTURE (1 cycle): write decoded digit/BLANK/ERR to working slot k, set mask[k].
//    Then WAIT: stay until DIG changes, then IDLE. Re-capturing the same k overwrites.
//  - Latency: DIG/SEG pin edge to slot write = 2 (sync) + STABLE_CYC + 1 cycles.
//  - Frame complete when mask is all ones: working bank copied to output regs, mask
//    cleared, FRAME_VLD=1 on the next cycle.
//  - Handshake: BCD/BLANK/ERR stable while FRAME_VLD=1 and FRAME_RDY=0. FRAME_VLD&
//    FRAME_RDY -> FRAME_VLD=0 next cycle unless a completed frame is copied the same
//    cycle, in which case FRAME_VLD stays 1 with new data. FRAME_RDY with FRAME_VLD=0
//    has no effect.
//  - Stall: capture continues into the working bank. Frame completing while FRAME_VLD=1
//    and FRAME_RDY=0 -> frame discarded, mask cleared, OVR=1. OVR clears on handshake.
//  - Simultaneous complete and handshake: handshake wins, new frame loaded, OVR unchanged.
//  - DIG all zero or multi-hot: never captured; mask retained. Only RST clears state.
// STRUCTURE
//  - Shared package seg7_pkg: pattern constants SEG7_0..SEG7_9, SEG7_BLANK, alternate
//    6/9 forms, BCD_ERR=4'hF, FSM state typedef {IDLE,SETTLE,CAPTURE,WAIT}.
//  - One sub-module seg7_pattern_dec: combinational 7-bit pattern -> {bcd[3:0],blank,err}.
//  - Top holds synchronizers, FSM, settle counter, working bank, output bank, handshake.
// TESTING
//  - Reset mid-SETTLE (RST pulse) -> all outputs 0, next frame needs all NDIG digits again.
//  - Scan 1,2,3,4 (DIG=0001..1000, STABLE_CYC+4 cycles each), RDY=1 -> FRAME_VLD 1 cycle,
//    BCD=16'h4321, BLANK=0, ERR=0.
//  - Digit 3 SEG=0000000, digit 2 SEG=1001001 -> BLANK=4'b1000, ERR=4'b0100,
//    BCD[15:8]=8'h0F.
//  - SEG glitch on cycle STABLE_CYC-2 -> counter restarts; capture delayed accordingly.
//  - RDY=0 across two full scans -> first frame held unchanged, OVR=1; RDY=1 -> VLD drops, OVR=0.
//  - DIG=0011 for 20 cycles -> no capture, mask and outputs unchanged.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan capture block.
// Segment patterns are ordered abcdefg, with bit 6 = a and bit 0 = g.
package seg7_pkg;

    localparam logic [6:0] SEG7_0     = 7'b1111110;
    localparam logic [6:0] SEG7_1     = 7'b0110000;
    localparam logic [6:0] SEG7_2     = 7'b1101101;
    localparam logic [6:0] SEG7_3     = 7'b1111001;
    localparam logic [6:0] SEG7_4     = 7'b0110011;
    localparam logic [6:0] SEG7_5     = 7'b1011011;
    localparam logic [6:0] SEG7_6     = 7'b1011111;
    localparam logic [6:0] SEG7_6_ALT = 7'b0011111;
    localparam logic [6:0] SEG7_7     = 7'b1110000;
    localparam logic [6:0] SEG7_8     = 7'b1111111;
    localparam logic [6:0] SEG7_9     = 7'b1111011;
    localparam logic [6:0] SEG7_9_ALT = 7'b1110011;
    localparam logic [6:0] SEG7_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_ERR = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        WAIT    = 2'd3
    } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational decode of one abcdefg segment pattern into BCD.
// The blank pattern reads as digit 0; any pattern outside the table reads as BCD_ERR.
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       blank,
    output logic       err
);

    always_comb begin
        bcd   = BCD_ERR;
        blank = 1'b0;
        err   = 1'b1;
        case (pattern)
            SEG7_0:             begin bcd = 4'd0; err = 1'b0; end
            SEG7_1:             begin bcd = 4'd1; err = 1'b0; end
            SEG7_2:             begin bcd = 4'd2; err = 1'b0; end
            SEG7_3:             begin bcd = 4'd3; err = 1'b0; end
            SEG7_4:             begin bcd = 4'd4; err = 1'b0; end
            SEG7_5:             begin bcd = 4'd5; err = 1'b0; end
            SEG7_6, SEG7_6_ALT: begin bcd = 4'd6; err = 1'b0; end
            SEG7_7:             begin bcd = 4'd7; err = 1'b0; end
            SEG7_8:             begin bcd = 4'd8; err = 1'b0; end
            SEG7_9, SEG7_9_ALT: begin bcd = 4'd9; err = 1'b0; end
            SEG7_BLANK:         begin bcd = 4'd0; blank = 1'b1; err = 1'b0; end
            default:            begin bcd = BCD_ERR; err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers one BCD digit per position from a scanned 7-segment display and
// delivers complete frames through a valid/ready handshake.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for a one-hot digit select
//   SETTLE  | counting cycles with SEG/DIG unchanged since the last latch
//   CAPTURE | writing the decoded digit into its working slot (one cycle)
//   WAIT    | digit captured; waiting for DIG to move away from it
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 8,
    parameter int CNT_W      = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [6:0]          SEG,
    input  logic [NDIG-1:0]     DIG,
    input  logic                FRAME_RDY,
    output logic                FRAME_VLD,
    output logic [4*NDIG-1:0]   BCD,
    output logic [NDIG-1:0]     BLANK,
    output logic [NDIG-1:0]     ERR,
    output logic                OVR
);

    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(STABLE_CYC - 1);
    localparam logic [NDIG-1:0]  DIG_ONE = NDIG'(1);
    localparam logic [NDIG-1:0]  MASK_FULL = {NDIG{1'b1}};

    logic [6:0]        seg_m, seg_s;
    logic [NDIG-1:0]   dig_m, dig_s;

    seg7_state_e       state;
    logic [CNT_W-1:0]  cnt;
    logic [NDIG-1:0]   lat_dig;
    logic [6:0]        lat_seg;

    logic [4*NDIG-1:0] work_bcd;
    logic [NDIG-1:0]   work_blank;
    logic [NDIG-1:0]   work_err;
    logic [NDIG-1:0]   mask;

    logic [4*NDIG-1:0] cap_bcd;
    logic [NDIG-1:0]   cap_blank;
    logic [NDIG-1:0]   cap_err;
    logic [NDIG-1:0]   cap_mask;

    logic [3:0]        dec_bcd;
    logic              dec_blank;
    logic              dec_err;

    logic              dig_onehot;
    logic              stable;
    logic              frame_done;
    logic              handshake;
    logic              load;

    // SEG and DIG are asynchronous to CLK; everything downstream uses the _s copies.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg_m <= '0;
            seg_s <= '0;
            dig_m <= '0;
            dig_s <= '0;
        end else begin
            seg_m <= SEG;
            seg_s <= seg_m;
            dig_m <= DIG;
            dig_s <= dig_m;
        end
    end

    assign dig_onehot = (dig_s != '0) && ((dig_s & (dig_s - DIG_ONE)) == '0);
    assign stable     = (dig_s == lat_dig) && (seg_s == lat_seg);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_dig <= '0;
            lat_seg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dig_onehot) begin
                        state   <= SETTLE;
                        cnt     <= '0;
                        lat_dig <= dig_s;
                        lat_seg <= seg_s;
                    end
                end
                SETTLE: begin
                    if (!dig_onehot) begin
                        state <= IDLE;
                    end else if (!stable) begin
                        cnt     <= '0;
                        lat_dig <= dig_s;
                        lat_seg <= seg_s;
                    end else if (cnt == CNT_TC) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (dig_s != lat_dig) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    seg7_pattern_dec u_dec (
        .pattern (lat_seg),
        .bcd     (dec_bcd),
        .blank   (dec_blank),
        .err     (dec_err)
    );

    // Working bank as it will look after this cycle's capture; used both for
    // the slot write and for loading the output bank on the completing capture.
    always_comb begin
        cap_bcd   = work_bcd;
        cap_blank = work_blank;
        cap_err   = work_err;
        cap_mask  = mask;
        for (int k = 0; k < NDIG; k++) begin
            if (lat_dig[k]) begin
                cap_bcd[4*k +: 4] = dec_bcd;
                cap_blank[k]      = dec_blank;
                cap_err[k]        = dec_err;
                cap_mask[k]       = 1'b1;
            end
        end
    end

    assign frame_done = (state == CAPTURE) && (cap_mask == MASK_FULL);
    assign handshake  = FRAME_VLD && FRAME_RDY;
    assign load       = frame_done && (!FRAME_VLD || FRAME_RDY);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            work_bcd   <= '0;
            work_blank <= '0;
            work_err   <= '0;
            mask       <= '0;
            BCD        <= '0;
            BLANK      <= '0;
            ERR        <= '0;
            FRAME_VLD  <= 1'b0;
            OVR        <= 1'b0;
        end else begin
            if (state == CAPTURE) begin
                work_bcd   <= cap_bcd;
                work_blank <= cap_blank;
                work_err   <= cap_err;
                mask       <= frame_done ? '0 : cap_mask;
            end

            // A frame completing on the handshake cycle replaces the consumed one;
            // OVR is left alone in that case and only clears on a plain handshake.
            if (load) begin
                BCD       <= cap_bcd;
                BLANK     <= cap_blank;
                ERR       <= cap_err;
                FRAME_VLD <= 1'b1;
            end else if (handshake) begin
                FRAME_VLD <= 1'b0;
                OVR       <= 1'b0;
            end

            if (frame_done && FRAME_VLD && !FRAME_RDY) begin
                OVR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed scenarios plus a randomized scan phase checked against a frame-level
// model: digit slots, a capture mask and a queue of expected frames.
module tb_seg7_scan_capture;

    localparam int NDIG = 4;
    localparam int S    = 8;
    localparam int HOLD = S + 8;

    typedef struct packed {
        logic [3:0] bcd;
        logic       blank;
        logic       err;
    } dec_t;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic [3:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic        rdy;
    logic        vld;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        ovr;

    logic [6:0] prim [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    logic [6:0] alt  [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b0011111, 7'b1110000, 7'b1111111, 7'b1110011};

    int     checks   = 0;
    int     failures = 0;
    logic   mon_en   = 1'b0;
    frame_t exp_q[$];

    always #5 clk = ~clk;

    seg7_scan_capture #(.NDIG(NDIG), .STABLE_CYC(S), .CNT_W(4)) dut (
        .CLK       (clk),
        .RST       (rst),
        .SEG       (seg),
        .DIG       (dig),
        .FRAME_RDY (rdy),
        .FRAME_VLD (vld),
        .BCD       (bcd),
        .BLANK     (blank),
        .ERR       (err),
        .OVR       (ovr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input int k, input logic [6:0] p, input int n);
        dig = 4'(1 << k);
        seg = p;
        cyc(n);
    endtask

    task automatic gap(input int n);
        dig = 4'b0000;
        cyc(n);
    endtask

    task automatic handshake_once();
        rdy = 1'b1;
        cyc(1);
        rdy = 1'b0;
    endtask

    function automatic dec_t ref_dec(input logic [6:0] p);
        dec_t r;
        r.bcd   = 4'hF;
        r.blank = 1'b0;
        r.err   = 1'b1;
        if (p == 7'b0000000) begin
            r.bcd   = 4'h0;
            r.blank = 1'b1;
            r.err   = 1'b0;
        end
        for (int d = 0; d < 10; d++) begin
            if (p == prim[d] || p == alt[d]) begin
                r.bcd = 4'(d);
                r.err = 1'b0;
            end
        end
        return r;
    endfunction

    // Output monitor for the random phase: every valid cycle must show the
    // oldest unconsumed expected frame; RDY is randomized here.
    always @(negedge clk) begin
        if (mon_en) begin
            if (vld) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_frame", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("rnd_bcd", bcd, exp_q[0].bcd);
                    check("rnd_blank", blank, exp_q[0].blank);
                    check("rnd_err", err, exp_q[0].err);
                    check("rnd_ovr", ovr, 1'b0);
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            if (vld && rdy && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [3:0]  m_bcd   [NDIG];
        logic        m_blank [NDIG];
        logic        m_err   [NDIG];
        logic [3:0]  m_mask;
        int          frames;
        int          prev_k;
        int          k;
        int          r;
        logic [6:0]  p;
        logic [3:0]  d;
        dec_t        dv;
        frame_t      f;

        rst = 1'b1;
        rdy = 1'b0;
        seg = 7'b0;
        dig = 4'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check("rst_vld", vld, 1'b0);
        check("rst_bcd", bcd, 16'h0);
        check("rst_blank", blank, 4'h0);
        check("rst_err", err, 4'h0);
        check("rst_ovr", ovr, 1'b0);

        // Basic scan with exact pin-to-frame latency on the last digit.
        gap(4);
        hold(0, prim[1], HOLD);
        hold(1, prim[2], HOLD);
        hold(2, prim[3], HOLD);
        gap(10);
        rdy = 1'b1;
        dig = 4'b1000;
        seg = prim[4];
        cyc(S + 3);
        check("lat_before", vld, 1'b0);
        cyc(1);
        check("lat_vld", vld, 1'b1);
        check("basic_bcd", bcd, 16'h4321);
        check("basic_blank", blank, 4'h0);
        check("basic_err", err, 4'h0);
        cyc(1);
        check("basic_vld_one_cycle", vld, 1'b0);
        cyc(HOLD - S - 5);

        // Blank and illegal digits, then a stalled second scan.
        rdy = 1'b0;
        hold(0, prim[5], HOLD);
        hold(1, alt[6], HOLD);
        hold(2, 7'b1001001, HOLD);
        hold(3, 7'b0000000, HOLD);
        check("be_vld", vld, 1'b1);
        check("be_bcd", bcd, 16'h0F65);
        check("be_blank", blank, 4'b1000);
        check("be_err", err, 4'b0100);
        check("be_ovr", ovr, 1'b0);
        hold(0, prim[7], HOLD);
        hold(1, prim[8], HOLD);
        hold(2, alt[9], HOLD);
        hold(3, prim[9], HOLD);
        check("stall_vld", vld, 1'b1);
        check("stall_bcd", bcd, 16'h0F65);
        check("stall_blank", blank, 4'b1000);
        check("stall_err", err, 4'b0100);
        check("stall_ovr", ovr, 1'b1);
        handshake_once();
        check("stall_release_vld", vld, 1'b0);
        check("stall_release_ovr", ovr, 1'b0);

        // SEG glitch two cycles before the settle count would expire.
        hold(0, prim[0], HOLD);
        hold(1, alt[9], HOLD);
        hold(2, prim[2], HOLD);
        gap(10);
        dig = 4'b1000;
        seg = prim[7];
        cyc(S - 2);
        seg = prim[7] ^ 7'b0000001;
        cyc(1);
        seg = prim[7];
        cyc(S + 3);
        check("glitch_before", vld, 1'b0);
        cyc(1);
        check("glitch_vld", vld, 1'b1);
        check("glitch_bcd", bcd, 16'h7290);
        handshake_once();
        check("glitch_release_vld", vld, 1'b0);

        // Multi-hot DIG never captures and leaves the partial mask intact.
        hold(0, prim[5], HOLD);
        hold(1, prim[3], HOLD);
        dig = 4'b0011;
        seg = prim[8];
        cyc(20);
        check("multihot_vld", vld, 1'b0);
        check("multihot_bcd", bcd, 16'h7290);
        hold(2, prim[1], HOLD);
        hold(3, prim[6], HOLD);
        check("multihot_after_vld", vld, 1'b1);
        check("multihot_after_bcd", bcd, 16'h6135);
        handshake_once();

        // Reset in the middle of settling clears outputs and the capture mask.
        hold(0, prim[8], HOLD);
        hold(1, prim[8], HOLD);
        hold(2, prim[8], HOLD);
        dig = 4'b1000;
        seg = prim[2];
        cyc(S / 2);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("midrst_vld", vld, 1'b0);
        check("midrst_bcd", bcd, 16'h0);
        check("midrst_blank", blank, 4'h0);
        check("midrst_err", err, 4'h0);
        check("midrst_ovr", ovr, 1'b0);
        cyc(HOLD);
        check("midrst_single_digit", vld, 1'b0);
        hold(0, prim[7], HOLD);
        hold(1, prim[0], HOLD);
        check("midrst_partial", vld, 1'b0);
        hold(2, prim[4], HOLD);
        check("midrst_full_vld", vld, 1'b1);
        check("midrst_full_bcd", bcd, 16'h2407);
        handshake_once();
        gap(10);

        // Randomized scans against the frame-level model.
        m_mask = 4'b0000;
        frames = 0;
        prev_k = -1;
        for (int i = 0; i < NDIG; i++) begin
            m_bcd[i]   = 4'h0;
            m_blank[i] = 1'b0;
            m_err[i]   = 1'b0;
        end
        mon_en = 1'b1;
        while (frames < 10) begin
            if ($urandom_range(0, 3) == 0) begin
                d = 4'($urandom_range(0, 15));
                if (d == 4'b0001 || d == 4'b0010 || d == 4'b0100 || d == 4'b1000) begin
                    d = 4'b0000;
                end
                dig = d;
                cyc($urandom_range(1, 20));
                prev_k = -1;
            end
            k = $urandom_range(0, NDIG - 1);
            if (k == prev_k) k = (k + 1) % NDIG;
            r = $urandom_range(0, 11);
            if (r < 10)       p = ($urandom_range(0, 1) != 0) ? alt[r] : prim[r];
            else if (r == 10) p = 7'b0000000;
            else              p = 7'($urandom_range(0, 127));

            dv          = ref_dec(p);
            m_bcd[k]    = dv.bcd;
            m_blank[k]  = dv.blank;
            m_err[k]    = dv.err;
            m_mask[k]   = 1'b1;
            if (m_mask == 4'b1111) begin
                for (int i = 0; i < NDIG; i++) begin
                    f.bcd[4*i +: 4] = m_bcd[i];
                    f.blank[i]      = m_blank[i];
                    f.err[i]        = m_err[i];
                end
                exp_q.push_back(f);
                m_mask = 4'b0000;
                frames++;
            end

            dig = 4'(1 << k);
            seg = p;
            if ($urandom_range(0, 3) == 0) begin
                cyc($urandom_range(1, S - 1));
                seg = p ^ 7'(1 << $urandom_range(0, 6));
                cyc(1);
                seg = p;
            end
            cyc(HOLD);
            prev_k = k;
        end
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            cyc(1);
        end
        check("rnd_drain", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        rdy    = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
